// File: rtl/cs_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cs_sequencer_pkg
//  Purpose  : Shared control-unit definitions for the microsequencer:
//             MIR COND field encoding, sequencer state enumeration and the
//             decode (instruction dispatch) microaddress construction.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cs_sequencer_pkg;

    // MIR COND field
    typedef enum logic [2:0] {
        COND_NEXT   = 3'd0,  // uPC + 1
        COND_N      = 3'd1,  // branch on N flag
        COND_Z      = 3'd2,  // branch on Z flag
        COND_V      = 3'd3,  // branch on V flag
        COND_C      = 3'd4,  // branch on C flag
        COND_IR13   = 3'd5,  // branch on IR[13]
        COND_JUMP   = 3'd6,  // unconditional jump
        COND_DECODE = 3'd7   // dispatch on instruction opcode
    } cond_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    // Width of the dispatch address {1, op, op3, 00}
    localparam int DECODE_W = 11;

    // Dispatch target: op = IR[31:30], op3 = IR[24:19]; each opcode owns a
    // 4-word slot in the upper half of the first 2K of control store.
    function automatic logic [DECODE_W-1:0] decode_addr(
        input logic [1:0] op,
        input logic [5:0] op3
    );
        return {1'b1, op, op3, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : cs_return_stack
//  Purpose  : LIFO of micro-subroutine return addresses.
//  Ports    : clk, rst_n       clock, async active-low reset (empties stack)
//             push, push_data  store push_data on top (ignored when full)
//             pop              discard top entry (ignored when empty)
//             top              current top-of-stack entry
//             empty, full      occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module cs_return_stack #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] entries [STACK_DEPTH];
    logic [SP_W:0]     count;      // one extra bit so "full" is distinguishable
    logic [SP_W-1:0]   wr_idx;
    logic [SP_W-1:0]   top_idx;

    assign wr_idx  = count[SP_W-1:0];
    // Modulo subtraction: when full, wr_idx wraps to 0 and top is DEPTH-1
    assign top_idx = wr_idx - SP_W'(1);
    assign top     = entries[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (SP_W + 1)'(STACK_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // Contents need no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cs_sequencer
//  Purpose  : Microprogram sequencer. Selects the next control-store address
//             from the MIR COND field, flags, IR and a return stack, and
//             stalls while a main-memory request awaits acknowledge.
//  Ports    : CLOCK_50, RESET_InLow          clock, async active-low reset
//             COND_InBUS, JUMP_ADDR_InBUS    MIR branch control / target
//             CALL_In, RET_In                MIR subroutine control
//             IR_InBUS, FLAGS_InBUS          instruction register, {N,Z,V,C}
//             RD_In, WR_In, ACK_In           memory request / acknowledge
//             ADDR_OutBUS                    registered microaddress (uPC)
//             STALL_Out                      waiting for ACK (combinational)
//             ERROR_Out                      sticky return-stack fault
//  Revision : 1.0  initial release
// ============================================================================
module cs_sequencer
    import cs_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic              CS_SEQUENCER_CLOCK_50,
    input  logic              CS_SEQUENCER_RESET_InLow,
    input  logic [2:0]        CS_SEQUENCER_COND_InBUS,
    input  logic [ADDR_W-1:0] CS_SEQUENCER_JUMP_ADDR_InBUS,
    input  logic              CS_SEQUENCER_CALL_In,
    input  logic              CS_SEQUENCER_RET_In,
    input  logic [31:0]       CS_SEQUENCER_IR_InBUS,
    input  logic [3:0]        CS_SEQUENCER_FLAGS_InBUS,
    input  logic              CS_SEQUENCER_RD_In,
    input  logic              CS_SEQUENCER_WR_In,
    input  logic              CS_SEQUENCER_ACK_In,
    output logic [ADDR_W-1:0] CS_SEQUENCER_ADDR_OutBUS,
    output logic              CS_SEQUENCER_STALL_Out,
    output logic              CS_SEQUENCER_ERROR_Out
);

    seq_state_t        state, state_next;
    logic [ADDR_W-1:0] upc, upc_next, upc_inc, target;
    logic              error_q, error_set;
    logic              stall, push, pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_empty, stk_full;
    logic              fault;
    logic              unused_ir;

    // Only opcode fields and IR[13] participate in sequencing
    assign unused_ir = ^{CS_SEQUENCER_IR_InBUS[29:25],
                         CS_SEQUENCER_IR_InBUS[18:14],
                         CS_SEQUENCER_IR_InBUS[12:0]};

    assign upc_inc = upc + 1'b1;   // wraps naturally at ADDR_W bits

    // COND-selected successor (before RET override)
    always_comb begin
        target = upc_inc;
        case (cond_t'(CS_SEQUENCER_COND_InBUS))
            COND_NEXT:   target = upc_inc;
            COND_N:      target = CS_SEQUENCER_FLAGS_InBUS[3] ? CS_SEQUENCER_JUMP_ADDR_InBUS : upc_inc;
            COND_Z:      target = CS_SEQUENCER_FLAGS_InBUS[2] ? CS_SEQUENCER_JUMP_ADDR_InBUS : upc_inc;
            COND_V:      target = CS_SEQUENCER_FLAGS_InBUS[1] ? CS_SEQUENCER_JUMP_ADDR_InBUS : upc_inc;
            COND_C:      target = CS_SEQUENCER_FLAGS_InBUS[0] ? CS_SEQUENCER_JUMP_ADDR_InBUS : upc_inc;
            COND_IR13:   target = CS_SEQUENCER_IR_InBUS[13]   ? CS_SEQUENCER_JUMP_ADDR_InBUS : upc_inc;
            COND_JUMP:   target = CS_SEQUENCER_JUMP_ADDR_InBUS;
            COND_DECODE: target = ADDR_W'(decode_addr(CS_SEQUENCER_IR_InBUS[31:30],
                                                      CS_SEQUENCER_IR_InBUS[24:19]));
            default:     target = upc_inc;
        endcase
    end

    assign fault = (CS_SEQUENCER_CALL_In && CS_SEQUENCER_RET_In)
                || (CS_SEQUENCER_RET_In  && stk_empty)
                || (CS_SEQUENCER_CALL_In && stk_full);

    // Next-state / next-address logic
    always_comb begin
        state_next = state;
        upc_next   = upc;
        stall      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        error_set  = 1'b0;
        case (state)
            ST_RUN, ST_WAIT: begin
                if ((CS_SEQUENCER_RD_In || CS_SEQUENCER_WR_In) && !CS_SEQUENCER_ACK_In) begin
                    stall      = 1'b1;
                    state_next = ST_WAIT;
                end else if (fault) begin
                    // Freeze everything; only reset leaves HALT
                    state_next = ST_HALT;
                    error_set  = 1'b1;
                end else begin
                    state_next = ST_RUN;
                    if (CS_SEQUENCER_RET_In) begin
                        upc_next = stk_top;
                        pop      = 1'b1;
                    end else begin
                        upc_next = target;
                        push     = CS_SEQUENCER_CALL_In;
                    end
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge CS_SEQUENCER_CLOCK_50 or negedge CS_SEQUENCER_RESET_InLow) begin
        if (!CS_SEQUENCER_RESET_InLow) begin
            state   <= ST_RUN;
            upc     <= ADDR_W'(RESET_ADDR);
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            upc   <= upc_next;
            if (error_set) begin
                error_q <= 1'b1;
            end
        end
    end

    cs_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (CS_SEQUENCER_CLOCK_50),
        .rst_n     (CS_SEQUENCER_RESET_InLow),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full)
    );

    assign CS_SEQUENCER_ADDR_OutBUS = upc;
    assign CS_SEQUENCER_STALL_Out   = stall;
    assign CS_SEQUENCER_ERROR_Out   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cs_sequencer
//  Purpose  : Self-checking bench for cs_sequencer (ADDR_W=11, depth 4).
//             A queue-based reference model predicts uPC, STALL and ERROR;
//             directed sequences pin known addresses, then random MIR
//             traffic runs against the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cs_sequencer;

    localparam int AW    = 11;
    localparam int DEPTH = 4;
    localparam int AMOD  = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [2:0]    cond;
    logic [AW-1:0] jump;
    logic          call, ret;
    logic [31:0]   ir;
    logic [3:0]    flags;
    logic          rd, wr, ack;
    logic [AW-1:0] addr;
    logic          stall, err;

    cs_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (0)
    ) dut (
        .CS_SEQUENCER_CLOCK_50        (clk),
        .CS_SEQUENCER_RESET_InLow     (rst_n),
        .CS_SEQUENCER_COND_InBUS      (cond),
        .CS_SEQUENCER_JUMP_ADDR_InBUS (jump),
        .CS_SEQUENCER_CALL_In         (call),
        .CS_SEQUENCER_RET_In          (ret),
        .CS_SEQUENCER_IR_InBUS        (ir),
        .CS_SEQUENCER_FLAGS_InBUS     (flags),
        .CS_SEQUENCER_RD_In           (rd),
        .CS_SEQUENCER_WR_In           (wr),
        .CS_SEQUENCER_ACK_In          (ack),
        .CS_SEQUENCER_ADDR_OutBUS     (addr),
        .CS_SEQUENCER_STALL_Out       (stall),
        .CS_SEQUENCER_ERROR_Out       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_upc;
    bit m_halt;
    bit m_err;
    bit m_stall;
    int m_stack[$];
    bit chk_en;
    int errors;
    int checks;

    task automatic m_reset();
        m_upc  = 0;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
    endtask

    function automatic int m_target();
        int nxt;
        nxt = (m_upc + 1) % AMOD;
        case (int'(cond))
            0:          return nxt;
            1, 2, 3, 4: return flags[4 - int'(cond)] ? int'(jump) : nxt;
            5:          return ir[13] ? int'(jump) : nxt;
            6:          return int'(jump);
            default:    return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_step();
        bit fault;
        if (!rst_n) begin
            m_reset();
        end else if (m_halt) begin
            // frozen until reset
        end else if ((rd || wr) && !ack) begin
            // stalled: nothing moves
        end else begin
            fault = (call && ret) || (ret && m_stack.size() == 0)
                 || (call && m_stack.size() == DEPTH);
            if (fault) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
            end else if (ret) begin
                m_upc = m_stack.pop_back();
            end else begin
                int t;
                t = m_target();
                if (call) m_stack.push_back((m_upc + 1) % AMOD);
                m_upc = t;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            checks++;
            if (addr !== AW'(m_upc)) begin
                errors++;
                $display("FAIL addr @%0t: got %h expected %h", $time, addr, AW'(m_upc));
            end
            checks++;
            if (stall !== m_stall) begin
                errors++;
                $display("FAIL stall @%0t: got %b expected %b", $time, stall, m_stall);
            end
            checks++;
            if (err !== m_err) begin
                errors++;
                $display("FAIL error @%0t: got %b expected %b", $time, err, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step_begin();
        @(negedge clk);
        #1;
    endtask

    task automatic step_end();
        if (!rst_n) m_reset();
        m_stall = !m_halt && (rd || wr) && !ack;
        @(posedge clk);
        model_step();
    endtask

    task automatic clear();
        cond = 3'd0; jump = '0; call = 1'b0; ret = 1'b0;
        ir = '0; flags = '0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    endtask

    // Leaves the caller inside a fresh step with reset released
    task automatic do_reset();
        step_begin();
        clear();
        rst_n = 1'b0;
        #1;
        lit("async_reset_addr", addr, AW'(0));
        lit("async_reset_err", AW'(err), AW'(0));
        step_end();
        step_begin();
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        chk_en = 1'b0;
        m_stall = 1'b0;
        rst_n = 1'b0;
        clear();
        m_reset();

        // Reset then sequential fetch: 0,1,2,3
        do_reset();
        chk_en = 1'b1;
        lit("seq_addr0", addr, AW'(0));
        step_end();
        step_begin(); lit("seq_addr1", addr, AW'(1)); step_end();
        step_begin(); lit("seq_addr2", addr, AW'(2)); step_end();
        step_begin(); lit("seq_addr3", addr, AW'(3));
        lit("seq_stall", AW'(stall), AW'(0));
        step_end();
        step_begin(); step_end();

        // Z branch taken from uPC=5
        step_begin();
        lit("at5", addr, AW'(5));
        cond = 3'd2; jump = AW'(11'h40); flags = 4'b0100;
        step_end();
        step_begin();
        lit("z_taken", addr, AW'(11'h40));

        // Z branch not taken from uPC=5
        do_reset();
        repeat (5) begin step_end(); step_begin(); end
        cond = 3'd2; jump = AW'(11'h40); flags = 4'b1011;
        step_end();
        step_begin();
        lit("z_not_taken", addr, AW'(6));

        // Decode dispatch
        do_reset();
        cond = 3'd7; ir = 32'h8000_0000;
        step_end();
        step_begin();
        lit("decode", addr, AW'(11'h600));

        // Memory stall for three cycles, then acknowledge
        clear();
        rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 lit("stall_hi", AW'(stall), AW'(1));
            step_end();
            step_begin();
            lit("stall_hold", addr, AW'(11'h600));
        end
        ack = 1'b1;
        #1 lit("stall_ack", AW'(stall), AW'(0));
        step_end();
        step_begin();
        lit("ack_advance", addr, AW'(11'h601));

        // Call / return
        clear();
        cond = 3'd6; jump = AW'(11'h10);
        step_end();
        step_begin();
        lit("at10", addr, AW'(11'h10));
        call = 1'b1; jump = AW'(11'h80);
        step_end();
        step_begin();
        lit("call_target", addr, AW'(11'h80));
        clear();
        ret = 1'b1;
        step_end();
        step_begin();
        lit("ret_addr", addr, AW'(11'h11));
        lit("ret_err", AW'(err), AW'(0));

        // Wrap at all-ones
        clear();
        cond = 3'd6; jump = AW'(11'h7FF);
        step_end();
        step_begin();
        lit("at7ff", addr, AW'(11'h7FF));
        cond = 3'd0;
        step_end();
        step_begin();
        lit("wrap", addr, AW'(0));
        lit("wrap_err", AW'(err), AW'(0));

        // Stack overflow on fifth nested call
        do_reset();
        cond = 3'd6; call = 1'b1;
        for (int k = 0; k < 5; k++) begin
            jump = AW'(11'h100 + k * 11'h10);
            step_end();
            step_begin();
            lit("nest_addr", addr, AW'(11'h100 + (k < 4 ? k : 3) * 11'h10));
            lit("nest_err", AW'(err), AW'(k == 4 ? 1 : 0));
        end
        // HALT ignores everything, including memory requests
        clear();
        rd = 1'b1;
        #1 lit("halt_stall", AW'(stall), AW'(0));
        step_end();
        step_begin();
        lit("halt_addr", addr, AW'(11'h130));
        lit("halt_err", AW'(err), AW'(1));

        // Return on empty stack
        do_reset();
        ret = 1'b1;
        step_end();
        step_begin();
        lit("underflow_err", AW'(err), AW'(1));
        lit("underflow_addr", addr, AW'(0));
        clear();
        step_end();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step_begin();
            if (m_halt) rst_n = ($urandom_range(0, 9) != 0);
            else        rst_n = ($urandom_range(0, 99) != 0);
            cond  = 3'($urandom_range(0, 7));
            jump  = AW'($urandom);
            call  = ($urandom_range(0, 7) == 0);
            ret   = ($urandom_range(0, 7) == 0);
            ir    = $urandom;
            flags = 4'($urandom);
            rd    = ($urandom_range(0, 3) == 0);
            wr    = ($urandom_range(0, 7) == 0);
            ack   = ($urandom_range(0, 1) == 0);
            step_end();
        end

        step_begin();
        #3;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
